// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and select constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // A producer in a later stage can feed an EX source register, but x0 never participates
  function automatic logic fwd_match(input logic wr_en, input logic [4:0] rd, input logic [4:0] rs);
    return wr_en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational EX operand forward select, EX/MEM over MEM/WB
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_EX,
  input  logic [4:0] rs2_EX,
  input  logic [4:0] rd_MEM,
  input  logic       RegWrite_MEM,
  input  logic [4:0] rd_WB,
  input  logic       RegWrite_WB,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Youngest producer wins: the EX/MEM value is newer than the MEM/WB value
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (fwd_match(RegWrite_MEM, rd_MEM, rs1_EX))     fwd_a = FWD_MEM;
    else if (fwd_match(RegWrite_WB, rd_WB, rs1_EX))  fwd_a = FWD_WB;
    if (fwd_match(RegWrite_MEM, rd_MEM, rs2_EX))     fwd_b = FWD_MEM;
    else if (fwd_match(RegWrite_WB, rd_WB, rs2_EX))  fwd_b = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control for the 5-stage pipeline (optional PIPE_CTRL_PERF_EN counters)
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 200,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [4:0]  rd_EX,
  input  logic        RegWrite_EX,
  input  logic [1:0]  ResultSrc_EX,
  input  logic        PCSrc_EX,
  input  logic [4:0]  rd_MEM,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  rd_WB,
  input  logic        RegWrite_WB,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic [1:0]  ForwardA_EX,
  output logic [1:0]  ForwardB_EX,
  output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  pipe_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              mem_err_q;
  logic              mem_stall;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;

  // Once in ERROR the pipeline stays frozen regardless of the memory handshake
  assign mem_stall = (state_q == ERROR) ? 1'b1 : (dmem_req & ~dmem_ready);

  assign load_use = RegWrite_EX && (ResultSrc_EX == RESULT_SRC_LOAD) && (rd_EX != 5'd0) &&
                    ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

  // Pipeline controls: memory freeze beats branch squash beats load-use bubble
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MEM = 1'b1;
      end else if (PCSrc_EX) begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end else if (load_use) begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_EX = 1'b1;
      end
    end
  end

  // Memory wait sequencing and timeout detection
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt == TIMEOUT) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // State, wait counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_cnt  <= wait_cnt_d;
      mem_err_q <= mem_err_q | (state_d == ERROR);
    end
  end

  assign mem_err = mem_err_q & ~rst;

  forward_unit u_forward_unit (
    .rs1_EX       (rs1_EX),
    .rs2_EX       (rs2_EX),
    .rd_MEM       (rd_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .rd_WB        (rd_WB),
    .RegWrite_WB  (RegWrite_WB),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign ForwardA_EX = rst ? FWD_RF : fwd_a;
  assign ForwardB_EX = rst ? FWD_RF : fwd_b;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  // Saturating event counters for stalled fetch cycles and front-end flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_IF && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_ID && (flush_events_q != 32'hFFFF_FFFF)) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_cycles_q;
  assign flush_events = rst ? 32'd0 : flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed plus randomized self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int T_OUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic       RegWrite_EX, RegWrite_MEM, RegWrite_WB, PCSrc_EX, dmem_req, dmem_ready;
  logic [1:0] ResultSrc_EX;
  logic       stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, mem_err;
  logic [1:0] ForwardA_EX, ForwardB_EX;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .ResultSrc_EX(ResultSrc_EX), .PCSrc_EX(PCSrc_EX),
    .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM), .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX),
    .ForwardA_EX(ForwardA_EX), .ForwardB_EX(ForwardB_EX), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "waiting" flag with elapsed-cycle count, sticky failure, event tallies
  bit     m_waiting, m_failed;
  int     m_elapsed;
  longint m_stalls, m_flushes;
  bit     e_stall, e_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (RegWrite_MEM && rd_MEM != 0 && rd_MEM == src) return 2'b10;
    if (RegWrite_WB && rd_WB != 0 && rd_WB == src) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the model, advance one clock, then update the model
  task automatic step();
    bit freeze, lu, e_sif, e_sid, e_sx, e_sm, e_fid, e_fx;
    #1;
    freeze = m_failed || (dmem_req && !dmem_ready);
    lu = RegWrite_EX && ResultSrc_EX == 2'b01 && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
    {e_sif, e_sid, e_sx, e_sm, e_fid, e_fx} = '0;
    if (!rst) begin
      if (freeze)        {e_sif, e_sid, e_sx, e_sm} = 4'b1111;
      else if (PCSrc_EX) {e_fid, e_fx} = 2'b11;
      else if (lu)       {e_sif, e_sid, e_fx} = 3'b111;
    end
    chk("stall_IF", stall_IF, e_sif);
    chk("stall_ID", stall_ID, e_sid);
    chk("stall_EX", stall_EX, e_sx);
    chk("stall_MEM", stall_MEM, e_sm);
    chk("flush_ID", flush_ID, e_fid);
    chk("flush_EX", flush_EX, e_fx);
    chk("ForwardA_EX", ForwardA_EX, rst ? 2'b00 : ref_fwd(rs1_EX));
    chk("ForwardB_EX", ForwardB_EX, rst ? 2'b00 : ref_fwd(rs2_EX));
    chk("mem_err", mem_err, !rst && m_failed);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cycles", stall_cycles, rst ? 32'd0 : 32'(m_stalls));
    chk("flush_events", flush_events, rst ? 32'd0 : 32'(m_flushes));
`endif
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_failed = 0; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_sif && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (e_fid && m_flushes < 64'hFFFF_FFFF) m_flushes++;
      if (!m_failed) begin
        if (!m_waiting) begin
          if (freeze) begin m_waiting = 1; m_elapsed = 1; end
        end else if (dmem_ready) begin
          m_waiting = 0; m_elapsed = 0;
        end else if (m_elapsed >= T_OUT) begin
          m_failed = 1; m_waiting = 0;
        end else begin
          m_elapsed++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_ID = 0; rs2_ID = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0; rd_MEM = 0; rd_WB = 0;
    RegWrite_EX = 0; RegWrite_MEM = 0; RegWrite_WB = 0; ResultSrc_EX = 0;
    PCSrc_EX = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    m_waiting = 0; m_failed = 0; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
    idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    rst = 0;
    chk("reset_state", dut.state_q, RUN);
    chk("reset_wait_cnt", dut.wait_cnt, 8'd0);
    step();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    rd_EX = 5; RegWrite_EX = 1; ResultSrc_EX = 2'b01; rs1_ID = 5; rs2_ID = 1;
    #1; chk("lu_stall_IF", stall_IF, 1'b1); chk("lu_flush_EX", flush_EX, 1'b1);
    step();
    rd_MEM = 5; RegWrite_MEM = 1; rs1_EX = 5; rs2_EX = 1;
    rd_EX = 0; RegWrite_EX = 0; ResultSrc_EX = 0; rs1_ID = 6; rs2_ID = 2;
    #1; chk("lu_fwdA", ForwardA_EX, 2'b10); chk("lu_clear", stall_IF, 1'b0);
    step();
    idle();

    // Branch with a matching load in the same cycle, then x0 never hazards
    rd_EX = 9; RegWrite_EX = 1; ResultSrc_EX = 2'b01; rs2_ID = 9; PCSrc_EX = 1;
    #1; chk("br_flush_ID", flush_ID, 1'b1); chk("br_stall_IF", stall_IF, 1'b0);
    step();
    PCSrc_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0;
    #1; chk("x0_stall_IF", stall_IF, 1'b0);
    step();
    idle();

    // Memory wait of 3 cycles with a branch held across it
    dmem_req = 1; PCSrc_EX = 1;
    repeat (3) step();
    dmem_ready = 1;
    #1; chk("mw_release_flush", flush_ID, 1'b1); chk("mw_release_stall", stall_MEM, 1'b0);
    step();
    chk("mw_state", dut.state_q, RUN);
    chk("mw_wait_cnt", dut.wait_cnt, 8'd0);
    idle();
    step();

    // Ready arrives exactly on the timeout cycle
    dmem_req = 1;
    repeat (T_OUT) step();
    dmem_ready = 1;
    step();
    chk("to_ready_state", dut.state_q, RUN);
    idle();
    step();

    // Timeout: ready never arrives
    dmem_req = 1;
    repeat (T_OUT + 1) step();
    dmem_req = 0;
    #1; chk("to_mem_err", mem_err, 1'b1); chk("to_stall", stall_IF, 1'b1);
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    chk("to_rst_state", dut.state_q, RUN);
    step();

    // Forward priority on operand B
    rd_MEM = 7; rd_WB = 7; rs2_EX = 7; RegWrite_MEM = 1; RegWrite_WB = 1;
    #1; chk("fwd_mem", ForwardB_EX, 2'b10);
    step();
    RegWrite_MEM = 0;
    #1; chk("fwd_wb", ForwardB_EX, 2'b01);
    step();
    rd_MEM = 0; rd_WB = 0; rs2_EX = 0; RegWrite_MEM = 1;
    #1; chk("fwd_x0", ForwardB_EX, 2'b00);
    step();
    idle();

`ifdef PIPE_CTRL_PERF_EN
    // Saturation: preload near the top and keep stalling
    dut.stall_cycles_q = 32'hFFFF_FFFE;
    m_stalls = 64'hFFFF_FFFE;
    dmem_req = 1;
    repeat (3) step();
    chk("sat_stall_cycles", stall_cycles, 32'hFFFF_FFFF);
    dmem_ready = 1;
    step();
    idle();
`endif

    // Randomized traffic over a small register range to provoke matches
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      rs1_ID       = 5'($urandom_range(0, 3));
      rs2_ID       = 5'($urandom_range(0, 3));
      rs1_EX       = 5'($urandom_range(0, 3));
      rs2_EX       = 5'($urandom_range(0, 3));
      rd_EX        = 5'($urandom_range(0, 3));
      rd_MEM       = 5'($urandom_range(0, 3));
      rd_WB        = 5'($urandom_range(0, 3));
      RegWrite_EX  = 1'($urandom);
      RegWrite_MEM = 1'($urandom);
      RegWrite_WB  = 1'($urandom);
      ResultSrc_EX = 2'($urandom);
      PCSrc_EX     = ($urandom_range(0, 4) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ready   = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
